// File: rtl/lcd_seq_engine_if.sv
// lcd_seq_engine_if: window, pixel, fill and output word channels of lcd_seq_engine
interface lcd_seq_engine_if #(parameter int DATA_W = 16);
  logic win_valid, win_ready;
  logic [15:0] win_x0, win_x1, win_y0, win_y1;
  logic pix_valid, pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic fill_valid, fill_ready;
  logic [DATA_W-1:0] fill_color;
  logic [19:0] fill_count;
  logic out_valid, out_ready, out_rs;
  logic [DATA_W-1:0] out_data;
  logic init_done, busy;
  modport master (
    output win_valid, win_x0, win_x1, win_y0, win_y1, pix_valid, pix_data,
           fill_valid, fill_color, fill_count, out_ready,
    input  win_ready, pix_ready, fill_ready, out_valid, out_rs, out_data, init_done, busy
  );
  modport slave (
    input  win_valid, win_x0, win_x1, win_y0, win_y1, pix_valid, pix_data,
           fill_valid, fill_color, fill_count, out_ready,
    output win_ready, pix_ready, fill_ready, out_valid, out_rs, out_data, init_done, busy
  );
endinterface

// File: rtl/lcd_seq_engine.sv
// lcd_seq_engine: LCD init, window address, pixel FIFO drain and LCD_FILL_EN-gated solid-fill word sequencer
module lcd_seq_engine #(
  parameter int DATA_W = 16,
  parameter int FIFO_AW = 4,
  parameter int SPLIT_ADDR = 1
) (
  input logic clk,
  input logic reset,
  lcd_seq_engine_if.slave bus
);
  typedef enum logic [2:0] {
    INIT, IDLE, CASET, RASET, RAMWR, PIXEL
`ifdef LCD_FILL_EN
    , FILL
`endif
  } state_t;
  localparam logic [0:7][7:0] INIT_C = {8'h11, 8'h13, 8'h29, 8'h3A, 8'h05, 8'h36, 8'h00, 8'h00};
  localparam logic [3:0] ADDR_LAST = SPLIT_ADDR != 0 ? 4'd7 : 4'd4;
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic init_done_q, init_done_d;
  logic [15:0] x0_q, x1_q, y0_q, y1_q;
  logic [DATA_W-1:0] mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0] cnt_q;
  logic push, pop, xfer, win_acc, a_cmd, i_rs, valid, rs;
  logic [1:0] b;
  logic [31:0] a;
  logic [7:0] cc;
  logic [DATA_W-1:0] data, a_word, i_word;
  function automatic logic [DATA_W-1:0] cmd(input logic [7:0] c, input logic [1:0] n);
    return DATA_W == 16 ? DATA_W'({c, 6'd0, n}) : DATA_W'(c);
  endfunction
`ifdef LCD_FILL_EN
  logic fill_acc;
  logic [DATA_W-1:0] fcol_q;
  logic [19:0] fcnt_q;
  assign bus.fill_ready = !reset && state_q == IDLE && init_done_q && !(|cnt_q) && !bus.win_valid;
  assign fill_acc = bus.fill_valid && bus.fill_ready;
  always_ff @(posedge clk) begin
    if (fill_acc) begin
      fcol_q <= bus.fill_color;
      fcnt_q <= bus.fill_count;
    end else if (state_q == FILL && xfer) fcnt_q <= fcnt_q - 20'd1;
  end
`else
  logic unused_fill;
  assign unused_fill = ^{bus.fill_valid, bus.fill_color, bus.fill_count};
  assign bus.fill_ready = 1'b0;
`endif
  assign xfer = bus.out_valid && bus.out_ready;
  assign push = bus.pix_valid && bus.pix_ready;
  assign pop = state_q == PIXEL && xfer;
  assign bus.pix_ready = !cnt_q[FIFO_AW];
  assign bus.win_ready = !reset && state_q == IDLE && init_done_q && !(|cnt_q);
  assign win_acc = bus.win_valid && bus.win_ready;
  assign bus.init_done = !reset && init_done_q;
  assign bus.busy = reset || state_q != IDLE || |cnt_q || bus.out_valid;
  assign i_rs = idx_q == 4'd4 || idx_q == 4'd6;
  assign i_word = i_rs ? DATA_W'(INIT_C[idx_q[2:0]]) : cmd(INIT_C[idx_q[2:0]], 2'd0);
  assign a = state_q == CASET ? {x0_q, x1_q} : {y0_q, y1_q};
  assign cc = state_q == CASET ? 8'h2A : 8'h2B;
  assign a_cmd = SPLIT_ADDR != 0 ? !idx_q[0] : idx_q == 4'd0;
  assign b = SPLIT_ADDR != 0 ? idx_q[2:1] : 2'(idx_q - 4'd1);
  assign a_word = a_cmd ? cmd(cc, SPLIT_ADDR != 0 ? b : 2'd0) : DATA_W'(a[{~b, 3'b000} +: 8]);
  assign bus.out_valid = valid && !reset;
  assign bus.out_rs = rs && !reset;
  assign bus.out_data = reset ? '0 : data;
  always_comb begin
    valid = 1'b1;
    rs = 1'b1;
    data = mem_q[rp_q];
    case (state_q)
      INIT: begin
        rs = i_rs;
        data = i_word;
      end
      CASET, RASET: begin
        rs = !a_cmd;
        data = a_word;
      end
      RAMWR: begin
        rs = 1'b0;
        data = cmd(8'h2C, 2'd0);
      end
      PIXEL: valid = |cnt_q;
`ifdef LCD_FILL_EN
      FILL: data = fcol_q;
`endif
      default: valid = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT: if (xfer) begin
        idx_d = idx_q == 4'd6 ? 4'd0 : idx_q + 4'd1;
        state_d = idx_q == 4'd6 ? IDLE : INIT;
        init_done_d = idx_q == 4'd6;
      end
      IDLE: begin
        state_d = init_done_q && |cnt_q ? PIXEL : win_acc ? CASET : IDLE;
`ifdef LCD_FILL_EN
        if (fill_acc && |bus.fill_count) state_d = FILL;
`endif
      end
      CASET, RASET: if (xfer) begin
        idx_d = idx_q == ADDR_LAST ? 4'd0 : idx_q + 4'd1;
        if (idx_q == ADDR_LAST) state_d = state_q == CASET ? RASET : RAMWR;
      end
      RAMWR: if (xfer) state_d = IDLE;
      PIXEL: if (!(|cnt_q)) state_d = IDLE;
`ifdef LCD_FILL_EN
      FILL: if (xfer && fcnt_q == 20'd1) state_d = IDLE;
`endif
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idx_q <= '0;
      init_done_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      init_done_q <= init_done_d;
      wp_q <= wp_q + FIFO_AW'(push);
      rp_q <= rp_q + FIFO_AW'(pop);
      cnt_q <= cnt_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.pix_data;
    if (win_acc) begin
      x0_q <= bus.win_x0;
      x1_q <= bus.win_x1;
      y0_q <= bus.win_y0;
      y1_q <= bus.win_y1;
    end
  end
endmodule
